// File: rtl/dsp_mac_seq_if.sv
// Operand stream and result handshake between a client and the dot-product sequencer.
// The client uses the master modport and the sequencer uses the slave modport.
interface dsp_mac_seq_if #(
  parameter int B_WIDTH = 18
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [24:0]        in_a;
  logic signed [B_WIDTH-1:0] in_b;
  logic                      res_valid;
  logic                      res_ready;
  logic [47:0]               res_data;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_mac_seq.sv
// Sequencer that drives a DSP slice (A/B/M/P registers) to accumulate sum(a_i*b_i) in P,
// then returns the final 48-bit P value over a valid/ready result port.
module dsp_mac_seq #(
  parameter int LEN_WIDTH = 8,
  parameter int A_WIDTH   = 30,
  parameter int B_WIDTH   = 18
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  dsp_mac_seq_if.slave         bus,
  output logic [A_WIDTH-1:0]   dsp_a,
  output logic [B_WIDTH-1:0]   dsp_b,
  output logic                 dsp_cea2,
  output logic                 dsp_ceb2,
  output logic                 dsp_cem,
  output logic                 dsp_cep,
  output logic [6:0]           dsp_opmode,
  output logic [3:0]           dsp_alumode,
  output logic [2:0]           dsp_carryinsel,
  input  logic [47:0]          dsp_p
);
  // Stage 1 = M register loaded, 2 = P register loaded, 3 = P visible on dsp_p.
  localparam int STAGES = 3;

  localparam logic [6:0] OP_LOAD = 7'b000_01_01;  // P = M
  localparam logic [6:0] OP_ACC  = 7'b010_01_01;  // P = P + M

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic                 first_q;
  logic [47:0]          res_q;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] first_pipe;
  logic [STAGES:1] last_pipe;

  logic fire, fire_first, fire_last, accept, capture;

  assign bus.in_ready = (state_q == RUN);
  assign fire         = bus.in_valid && bus.in_ready;
  assign fire_first   = fire && first_q;
  assign fire_last    = fire && (cnt_q == LEN_WIDTH'(1));
  assign accept       = (state_q == IDLE) && start && (len != '0);
  assign capture      = (state_q == DRAIN) && last_pipe[STAGES];

  // Next-state and status outputs
  always_comb begin
    state_d       = state_q;
    busy          = (state_q != IDLE);
    bus.res_valid = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (fire_last) state_d = DRAIN;
      DRAIN:   if (capture) state_d = OUT;
      OUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= len;
      first_q <= 1'b1;
    end else if (fire) begin
      cnt_q   <= cnt_q - LEN_WIDTH'(1);
      first_q <= 1'b0;
    end
  end

  // Stages never stall: tags simply follow the pair down the slice pipeline.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], fire};
      first_pipe <= {first_pipe[STAGES-1:1], fire_first};
      last_pipe  <= {last_pipe[STAGES-1:1], fire_last};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)        res_q <= '0;
    else if (capture) res_q <= dsp_p;
  end

  assign bus.res_data = res_q;

  // Slice drive: A/B captured on fire, M and P enables follow the stage valids.
  assign dsp_a          = {{(A_WIDTH-25){bus.in_a[24]}}, bus.in_a};
  assign dsp_b          = bus.in_b;
  assign dsp_cea2       = fire;
  assign dsp_ceb2       = fire;
  assign dsp_cem        = vld_pipe[1];
  assign dsp_cep        = vld_pipe[2];
  // Z=0 on the first product makes any stale P from before reset irrelevant.
  assign dsp_opmode     = vld_pipe[2] ? (first_pipe[2] ? OP_LOAD : OP_ACC) : 7'b0;
  assign dsp_alumode    = 4'b0000;
  assign dsp_carryinsel = 3'b000;
endmodule
